instr_fetch: RTL and testbench

Instruction fetch unit: owns the program counter, reads instruction words from instruction memory over a single-outstanding request/acknowledge interface, and presents each word with its opcode and function fields to the control unit under a valid/ready handshake. It closes the loop from the decoder: the control unit's branch and jump outputs, plus the ALU zero flag, come back here when the instruction is accepted and select the next PC. It sits between instruction memory and control_unit, at the front of the datapath.

---
 rtl/instr_fetch_pkg.sv | 27 ++
 rtl/instr_fetch_next_pc_calc.sv | 38 +++
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared MIPS instruction-field definitions and fetch FSM state type.
// Imported by instr_fetch, next_pc_calc and control_unit.
package instr_fetch_pkg;

    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] JUMP  = 6'h02;

    localparam int unsigned OPCODE_MSB   = 31;
    localparam int unsigned OPCODE_LSB   = 26;
    localparam int unsigned FUNCT_MSB    = 5;
    localparam int unsigned FUNCT_LSB    = 0;
    localparam int unsigned IMM16_MSB    = 15;
    localparam int unsigned IMM16_LSB    = 0;
    localparam int unsigned TARGET26_MSB = 25;
    localparam int unsigned TARGET26_LSB = 0;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_next_pc_calc.sv
// Next-PC selection for an accepted instruction: jump, taken branch, or PC+4.
// Purely combinational; all arithmetic wraps modulo 2^ADDR_WIDTH_P.
module next_pc_calc
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH_P = 32
) (
    input  logic [ADDR_WIDTH_P-1:0] pc,
    input  logic [31:0]             instr,
    input  logic                    branch,
    input  logic                    zero,
    input  logic                    jump,
    output logic [ADDR_WIDTH_P-1:0] next_pc
);

    logic [ADDR_WIDTH_P-1:0] p4;
    logic [ADDR_WIDTH_P-1:0] jump_target;
    logic [ADDR_WIDTH_P-1:0] branch_target;
    logic [15:0]             imm16;
    logic                    unused_opcode;

    assign imm16         = instr[IMM16_MSB:IMM16_LSB];
    assign unused_opcode = ^instr[OPCODE_MSB:OPCODE_LSB];

    always_comb begin
        p4            = pc + ADDR_WIDTH_P'(4);
        jump_target   = {p4[ADDR_WIDTH_P-1:28], instr[TARGET26_MSB:TARGET26_LSB], 2'b00};
        branch_target = p4 + {{(ADDR_WIDTH_P-18){imm16[15]}}, imm16, 2'b00};
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end else begin
            next_pc = p4;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, single-outstanding imem read, and a
// valid/ready hand-off of the fetched word to the control unit.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH_P = 32,
    parameter int unsigned          DATA_WIDTH_P = 32,
    parameter logic [ADDR_WIDTH_P-1:0] RESET_PC_P = RESET_PC
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    output logic                    o_imem_req,
    output logic [ADDR_WIDTH_P-1:0] o_imem_addr,
    input  logic                    i_imem_ack,
    input  logic [DATA_WIDTH_P-1:0] i_imem_rdata,
    output logic                    o_instr_valid,
    input  logic                    i_instr_ready,
    output logic [DATA_WIDTH_P-1:0] o_instr,
    output logic [5:0]              o_opcode,
    output logic [5:0]              o_function,
    output logic [ADDR_WIDTH_P-1:0] o_pc,
    output logic [ADDR_WIDTH_P-1:0] o_pc_plus4,
    input  logic                    i_branch,
    input  logic                    i_zero,
    input  logic                    i_jump
);

    fetch_state_e            state_q, state_d;
    logic                    req_q, req_d;
    logic                    valid_q, valid_d;
    logic [ADDR_WIDTH_P-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH_P-1:0] pc_plus4_q, pc_plus4_d;
    logic [DATA_WIDTH_P-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH_P-1:0] next_pc;
    logic                    capture;
    logic                    accept;

    // req_q stays low for the first post-reset cycle, so an ack is only
    // honoured once the request is actually visible on the port.
    assign capture = (state_q == ST_FETCH) && req_q && i_imem_ack;
    assign accept  = (state_q == ST_HOLD) && valid_q && i_instr_ready;

    next_pc_calc #(
        .ADDR_WIDTH_P(ADDR_WIDTH_P)
    ) u_next_pc_calc (
        .pc      (pc_q),
        .instr   (instr_q[31:0]),
        .branch  (i_branch),
        .zero    (i_zero),
        .jump    (i_jump),
        .next_pc (next_pc)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_FETCH;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            pc_q       <= RESET_PC_P;
            pc_plus4_q <= RESET_PC_P + ADDR_WIDTH_P'(4);
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (capture) state_d = ST_HOLD;
            ST_HOLD:  if (accept)  state_d = ST_FETCH;
            default:               state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        req_d   = (state_d == ST_FETCH);
        valid_d = (state_d == ST_HOLD);
    end

    // Control inputs only reach the PC through the accept mux.
    always_comb begin
        instr_d    = capture ? i_imem_rdata : instr_q;
        pc_d       = accept ? next_pc : pc_q;
        pc_plus4_d = pc_d + ADDR_WIDTH_P'(4);
    end

    assign o_imem_req    = req_q;
    assign o_imem_addr   = pc_q;
    assign o_instr_valid = valid_q;
    assign o_instr       = instr_q;
    assign o_opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign o_function    = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign o_pc          = pc_q;
    assign o_pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: chained fetch vectors with a
// scoreboard of fetched words, plus reset-in-FETCH/HOLD sequences.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instr;
    logic [5:0]  o_opcode;
    logic [5:0]  o_function;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        i_branch;
    logic        i_zero;
    logic        i_jump;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        br;
        logic        zr;
        logic        jp;
        int unsigned ack_dly;
        int unsigned rdy_dly;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    localparam int unsigned NVEC = 16;
    vec_t vecs[NVEC];
    exp_t sb[$];

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_WIDTH_P(32),
        .DATA_WIDTH_P(32),
        .RESET_PC_P  (32'h0000_0000)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_instr       (o_instr),
        .o_opcode      (o_opcode),
        .o_function    (o_function),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4),
        .i_branch      (i_branch),
        .i_zero        (i_zero),
        .i_jump        (i_jump)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic rand_ctrl();
        {i_branch, i_zero, i_jump} = 3'($urandom);
    endtask

    // Pop the next expected word and compare every instruction-side output.
    task automatic chk_presented(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(o_instr_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_instr"}, o_instr, e.instr);
            chk({tag, "_pc"}, o_pc, e.pc);
            chk({tag, "_pc_plus4"}, o_pc_plus4, e.pc + 32'd4);
            chk({tag, "_opcode"}, 32'(o_opcode), 32'(e.instr[31:26]));
            chk({tag, "_function"}, 32'(o_function), 32'(e.instr[5:0]));
        end
    endtask

    initial begin
        logic [31:0] held_instr;

        vecs[0]  = '{32'h0000_0000, {RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{32'h0000_0004, {RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 1'b0, 1'b0, 1'b0, 3, 4};
        vecs[2]  = '{32'h0000_0008, {JUMP, 26'h000_0000},                  1'b0, 1'b0, 1'b1, 0, 0};
        vecs[3]  = '{32'h0000_0000, {JUMP, 26'h000_0010},                  1'b0, 1'b0, 1'b1, 1, 0};
        vecs[4]  = '{32'h0000_0040, {BEQ, 5'd0, 5'd0, 16'h0003},           1'b1, 1'b1, 1'b0, 0, 2};
        vecs[5]  = '{32'h0000_0050, {JUMP, 26'h000_0010},                  1'b0, 1'b1, 1'b1, 0, 0};
        vecs[6]  = '{32'h0000_0040, {BEQ, 5'd0, 5'd0, 16'h0003},           1'b1, 1'b0, 1'b0, 2, 1};
        vecs[7]  = '{32'h0000_0044, {JUMP, 26'h000_0000},                  1'b0, 1'b0, 1'b1, 0, 0};
        vecs[8]  = '{32'h0000_0000, {BEQ, 5'd0, 5'd0, 16'hFFFF},           1'b1, 1'b1, 1'b0, 0, 0};
        vecs[9]  = '{32'h0000_0000, {BEQ, 5'd0, 5'd0, 16'hFFFE},           1'b1, 1'b1, 1'b0, 1, 1};
        vecs[10] = '{32'hFFFF_FFFC, {LW, 5'd1, 5'd2, 16'h0000},            1'b0, 1'b1, 1'b0, 0, 0};
        vecs[11] = '{32'h0000_0000, {JUMP, 26'h3FF_FFFF},                  1'b0, 1'b0, 1'b1, 0, 0};
        vecs[12] = '{32'h0FFF_FFFC, {SW, 5'd1, 5'd2, 16'h0004},            1'b0, 1'b1, 1'b0, 0, 3};
        vecs[13] = '{32'h1000_0000, {JUMP, 26'h000_0100},                  1'b1, 1'b1, 1'b1, 0, 0};
        vecs[14] = '{32'h1000_0400, {BEQ, 5'd0, 5'd0, 16'h0003},           1'b1, 1'b0, 1'b0, 0, 0};
        vecs[15] = '{32'h1000_0404, {6'h3F, 26'h000_0005},                 1'b0, 1'b0, 1'b1, 0, 0};

        // Reset with an ack asserted throughout: nothing may be captured.
        i_rst_n       = 1'b0;
        i_imem_ack    = 1'b1;
        i_imem_rdata  = 32'hDEAD_BEEF;
        i_instr_ready = 1'b0;
        {i_branch, i_zero, i_jump} = 3'b000;
        repeat (3) step();
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_addr", o_imem_addr, 32'h0000_0000);
        chk("rst_pc", o_pc, 32'h0000_0000);
        chk("rst_pc_plus4", o_pc_plus4, 32'h0000_0004);
        chk("rst_instr", o_instr, 32'h0000_0000);
        i_rst_n    = 1'b1;
        i_imem_ack = 1'b0;
        step();

        for (int v = 0; v < int'(NVEC); v++) begin
            chk($sformatf("v%0d_req", v), 32'(o_imem_req), 32'd1);
            chk($sformatf("v%0d_addr", v), o_imem_addr, vecs[v].pc);
            chk($sformatf("v%0d_valid_lo", v), 32'(o_instr_valid), 32'd0);
            for (int w = 0; w < int'(vecs[v].ack_dly); w++) begin
                i_imem_ack   = 1'b0;
                i_imem_rdata = $urandom;
                rand_ctrl();
                step();
                chk($sformatf("v%0d_wait_addr", v), o_imem_addr, vecs[v].pc);
                chk($sformatf("v%0d_wait_req", v), 32'(o_imem_req), 32'd1);
            end
            i_imem_ack   = 1'b1;
            i_imem_rdata = vecs[v].instr;
            sb.push_back('{vecs[v].pc, vecs[v].instr});
            rand_ctrl();
            step();
            i_imem_ack = 1'b0;
            chk_presented($sformatf("v%0d", v));
            chk($sformatf("v%0d_req_lo", v), 32'(o_imem_req), 32'd0);
            for (int r = 0; r < int'(vecs[v].rdy_dly); r++) begin
                i_instr_ready = 1'b0;
                i_imem_ack    = 1'($urandom);
                i_imem_rdata  = $urandom;
                rand_ctrl();
                step();
                chk($sformatf("v%0d_hold_valid", v), 32'(o_instr_valid), 32'd1);
                chk($sformatf("v%0d_hold_instr", v), o_instr, vecs[v].instr);
                chk($sformatf("v%0d_hold_pc", v), o_pc, vecs[v].pc);
            end
            i_instr_ready = 1'b1;
            i_imem_ack    = 1'b1;
            i_imem_rdata  = $urandom;
            {i_branch, i_zero, i_jump} = {vecs[v].br, vecs[v].zr, vecs[v].jp};
            step();
            i_instr_ready = 1'b0;
            i_imem_ack    = 1'b0;
            rand_ctrl();
            chk($sformatf("v%0d_valid_drop", v), 32'(o_instr_valid), 32'd0);
        end
        chk("last_req", 32'(o_imem_req), 32'd1);
        chk("last_addr", o_imem_addr, 32'h1000_0014);

        // One-cycle reset while FETCH is outstanding, with a coincident ack.
        i_rst_n      = 1'b0;
        i_imem_ack   = 1'b1;
        i_imem_rdata = 32'hCAFE_F00D;
        step();
        i_rst_n    = 1'b1;
        i_imem_ack = 1'b0;
        chk("rf_req", 32'(o_imem_req), 32'd0);
        chk("rf_valid", 32'(o_instr_valid), 32'd0);
        chk("rf_addr", o_imem_addr, 32'h0000_0000);
        chk("rf_instr", o_instr, 32'h0000_0000);
        step();
        chk("rf_req_after", 32'(o_imem_req), 32'd1);
        chk("rf_addr_after", o_imem_addr, 32'h0000_0000);

        held_instr   = {RTYPE, 5'd4, 5'd5, 5'd6, 5'd0, 6'h25};
        i_imem_ack   = 1'b1;
        i_imem_rdata = held_instr;
        sb.push_back('{32'h0000_0000, held_instr});
        step();
        i_imem_ack = 1'b0;
        chk_presented("rh_pre");

        // One-cycle reset while HOLD, with ready and jump asserted.
        i_rst_n       = 1'b0;
        i_instr_ready = 1'b1;
        i_imem_ack    = 1'b1;
        i_imem_rdata  = 32'h1234_5678;
        {i_branch, i_zero, i_jump} = 3'b111;
        step();
        i_rst_n       = 1'b1;
        i_instr_ready = 1'b0;
        i_imem_ack    = 1'b0;
        chk("rh_valid", 32'(o_instr_valid), 32'd0);
        chk("rh_instr", o_instr, 32'h0000_0000);
        chk("rh_req", 32'(o_imem_req), 32'd0);
        chk("rh_pc", o_pc, 32'h0000_0000);
        step();
        chk("rh_req_after", 32'(o_imem_req), 32'd1);
        chk("rh_addr_after", o_imem_addr, 32'h0000_0000);

        held_instr   = {SW, 5'd7, 5'd8, 16'h0010};
        i_imem_ack   = 1'b1;
        i_imem_rdata = held_instr;
        sb.push_back('{32'h0000_0000, held_instr});
        step();
        i_imem_ack = 1'b0;
        chk_presented("rh_post");
        i_instr_ready = 1'b1;
        {i_branch, i_zero, i_jump} = 3'b000;
        step();
        i_instr_ready = 1'b0;
        chk("rh_next_addr", o_imem_addr, 32'h0000_0004);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
